sr_bank_ctrl: RTL



---
 rtl/sr_pkg.sv | 31 +++
 rtl/rr_arbiter.sv | 36 +++
 rtl/sr_bank_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/sr_pkg.sv
// Shared definitions for the SR latch bank write controller: FSM state encoding,
// counter-width helper and default pulse/settle timing.
package sr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GRANT  = 3'd1,
    ST_PULSE  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_VERIFY = 3'd4,
    ST_ACK    = 3'd5
  } state_t;

  localparam int DEF_PULSE_CYC  = 2;
  localparam int DEF_SETTLE_CYC = 1;

  // Ceiling log2, never below 1 so it can size a vector directly
  function automatic int clog2(input int value);
    int res;
    res = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        res = i + 1;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping
// modulo NREQ; returns the winner as one-hot and as an index.
module rr_arbiter
  import sr_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [PW-1:0]   idx
);

  logic          found_s;
  logic [PW-1:0] cand_s;

  // Scan requesters starting at the pointer, keep the first hit
  always_comb begin
    found_s = 1'b0;
    cand_s  = '0;
    onehot  = '0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_s = PW'((int'(ptr) + k) % NREQ);
      if (!found_s && req[cand_s]) begin
        found_s        = 1'b1;
        onehot[cand_s] = 1'b1;
        idx            = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/sr_bank_ctrl.sv
// Write controller for a bank of SR latches sharing one set/reset drive path.
// Optional read-back verify with one retry is enabled by defining SR_VERIFY_EN.
module sr_bank_ctrl
  import sr_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int DEPTH      = 8,
  parameter int AW         = 3,
  parameter int PULSE_CYC  = DEF_PULSE_CYC,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ-1:0]    req_data,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    ack,
  output logic [DEPTH-1:0]   s_out,
  output logic [DEPTH-1:0]   r_out,
  input  logic [DEPTH-1:0]   q_in,
  output logic               busy,
  output logic               err
);

  localparam int PW   = clog2(NREQ);
  localparam int CMAX = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
  localparam int CW   = clog2(CMAX + 1);
  localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] PULSE_LD  = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] SETTLE_LD = (SETTLE_CYC > 0) ? CW'(SETTLE_CYC - 1) : '0;
`ifdef SR_VERIFY_EN
  localparam state_t POST_SETTLE = ST_VERIFY;
`else
  localparam state_t POST_SETTLE = ST_ACK;
`endif

  state_t          state_r;
  logic [PW-1:0]   ptr_r;
  logic [PW-1:0]   win_r;
  logic [NREQ-1:0] win_oh_r;
  logic [AW-1:0]   addr_r;
  logic            data_r;
  logic [CW-1:0]   cnt_r;
  logic [NREQ-1:0] gnt_r;
  logic [NREQ-1:0] ack_r;
  logic [DEPTH-1:0] s_r;
  logic [DEPTH-1:0] r_r;
  logic            busy_r;
  logic [NREQ-1:0] arb_oh_s;
  logic [PW-1:0]   arb_idx_s;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .req    (req),
    .ptr    (ptr_r),
    .onehot (arb_oh_s),
    .idx    (arb_idx_s)
  );

`ifdef SR_VERIFY_EN
  logic err_r;
  logic retry_r;
  assign err = err_r;
`else
  logic unused_q_s;
  assign unused_q_s = ^q_in;
  assign err        = 1'b0;
`endif

  assign gnt   = gnt_r;
  assign ack   = ack_r;
  assign s_out = s_r;
  assign r_out = r_r;
  assign busy  = busy_r;

  // FSM plus outputs registered from the current state (one cycle behind it)
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_r  <= ST_IDLE;
      ptr_r    <= '0;
      win_r    <= '0;
      win_oh_r <= '0;
      addr_r   <= '0;
      data_r   <= 1'b0;
      cnt_r    <= '0;
      gnt_r    <= '0;
      ack_r    <= '0;
      s_r      <= '0;
      r_r      <= '0;
      busy_r   <= 1'b0;
`ifdef SR_VERIFY_EN
      err_r    <= 1'b0;
      retry_r  <= 1'b0;
`endif
    end else begin
      gnt_r  <= (state_r != ST_IDLE) ? win_oh_r : '0;
      ack_r  <= (state_r == ST_ACK) ? win_oh_r : '0;
      busy_r <= (state_r != ST_IDLE);
      s_r    <= '0;
      r_r    <= '0;
      if (state_r == ST_PULSE) begin
        if (data_r) begin
          s_r[addr_r] <= 1'b1;
        end else begin
          r_r[addr_r] <= 1'b1;
        end
      end else begin
        cnt_r <= cnt_r;
      end

      case (state_r)
        ST_IDLE: begin
          if (|req) begin
            win_r    <= arb_idx_s;
            win_oh_r <= arb_oh_s;
            addr_r   <= req_addr[arb_idx_s*AW +: AW];
            data_r   <= req_data[arb_idx_s];
            state_r  <= ST_GRANT;
`ifdef SR_VERIFY_EN
            retry_r  <= 1'b0;
`endif
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          // Addresses past the bank are acknowledged without any drive
          if ({1'b0, addr_r} >= DEPTH_W) begin
            state_r <= ST_ACK;
          end else begin
            state_r <= ST_PULSE;
            cnt_r   <= PULSE_LD;
          end
        end
        ST_PULSE: begin
          if (cnt_r != '0) begin
            cnt_r <= cnt_r - 1'b1;
          end else if (SETTLE_CYC > 0) begin
            state_r <= ST_SETTLE;
            cnt_r   <= SETTLE_LD;
          end else begin
            state_r <= POST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (cnt_r != '0) begin
            cnt_r <= cnt_r - 1'b1;
          end else begin
            state_r <= POST_SETTLE;
          end
        end
        ST_VERIFY: begin
`ifdef SR_VERIFY_EN
          if (q_in[addr_r] == data_r) begin
            state_r <= ST_ACK;
          end else if (!retry_r) begin
            retry_r <= 1'b1;
            state_r <= ST_PULSE;
            cnt_r   <= PULSE_LD;
          end else begin
            err_r   <= 1'b1;
            state_r <= ST_ACK;
          end
`else
          state_r <= ST_ACK;
`endif
        end
        ST_ACK: begin
          ptr_r   <= (win_r == PW'(NREQ - 1)) ? '0 : win_r + 1'b1;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
